// File: rtl/axi_lite_mst_seq.sv
// Purpose : single-outstanding AXI4-Lite master that converts one-cycle wr_cmd/rd_cmd pulses into AW/W/B or AR/R transactions.
// Latency : command at cycle 0, valids at cycle 1; with a zero-wait slave done_out rises at cycle 3 and the next command is accepted in that cycle.
// Backpr. : each valid is held until its own handshake; the FSM waits indefinitely for B/R; commands arriving while busy are dropped (cmd_drop pulse).
//
// Optional macro AXI_LITE_MST_CMD_BUF_EN: adds a one-entry command buffer (type, addr, data).
// A command arriving while busy is then held instead of dropped and is launched from IDLE on the
// cycle after the current completion. A command that finds the buffer full is dropped.
//
// Ports: clk/rstn (async active-low reset); addr_in/data_in/wr_cmd/rd_cmd from the command block;
// done_out/status_out/rdata_out/busy/cmd_drop back to it; m_aw*/m_w*/m_b*/m_ar*/m_r* AXI4-Lite master.
module axi_lite_mst_seq #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [2:0] PROT   = 3'b000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                wr_cmd,
    input  logic                rd_cmd,
    output logic                done_out,
    output logic [1:0]          status_out,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                busy,
    output logic                cmd_drop,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t              state_q, state_d;
    logic                launch_wr, launch_rd, store, drop;
    logic [ADDR_W-1:0]   launch_addr;
    logic [DATA_W-1:0]   launch_data;
    logic                aw_ok, w_ok;

`ifdef AXI_LITE_MST_CMD_BUF_EN
    logic                buf_vld;
    logic                buf_wr;
    logic [ADDR_W-1:0]   buf_addr;
    logic [DATA_W-1:0]   buf_data;
`endif

    assign m_awprot = PROT;
    assign m_arprot = PROT;
    assign busy     = (state_q != IDLE);

    // A channel counts as done once its valid has dropped or is handshaking this cycle.
    assign aw_ok = ~m_awvalid | m_awready;
    assign w_ok  = ~m_wvalid  | m_wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        launch_wr   = 1'b0;
        launch_rd   = 1'b0;
        launch_addr = addr_in;
        launch_data = data_in;
        store       = 1'b0;
        drop        = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef AXI_LITE_MST_CMD_BUF_EN
                // A buffered command goes first; a fresh command in the same cycle takes its slot.
                if (buf_vld) begin
                    launch_wr   = buf_wr;
                    launch_rd   = ~buf_wr;
                    launch_addr = buf_addr;
                    launch_data = buf_data;
                    store       = wr_cmd | rd_cmd;
                    drop        = wr_cmd & rd_cmd;
                end else
`endif
                begin
                    // Simultaneous pulses: the write wins, the read is discarded.
                    launch_wr = wr_cmd;
                    launch_rd = rd_cmd & ~wr_cmd;
                    drop      = wr_cmd & rd_cmd;
                end
                if (launch_wr)      state_d = WR_REQ;
                else if (launch_rd) state_d = RD_REQ;
            end
            WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
            WR_RESP: if (m_bvalid)      state_d = IDLE;
            RD_REQ:  if (m_arready)     state_d = RD_RESP;
            RD_RESP: if (m_rvalid)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && (wr_cmd || rd_cmd)) begin
`ifdef AXI_LITE_MST_CMD_BUF_EN
            if (!buf_vld) begin
                store = 1'b1;
                drop  = wr_cmd & rd_cmd;
            end else begin
                drop  = 1'b1;
            end
`else
            drop = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_out   <= 1'b0;
            status_out <= 2'b00;
            rdata_out  <= '0;
            cmd_drop   <= 1'b0;
            m_awaddr   <= '0;
            m_awvalid  <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_araddr   <= '0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
`ifdef AXI_LITE_MST_CMD_BUF_EN
            buf_vld    <= 1'b0;
            buf_wr     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
`endif
        end else begin
            cmd_drop <= drop;
            if (launch_wr) begin
                m_awaddr  <= launch_addr;
                m_wdata   <= launch_data;
                m_wstrb   <= '1;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                done_out  <= 1'b0;
            end
            if (launch_rd) begin
                m_araddr  <= launch_addr;
                m_arvalid <= 1'b1;
                done_out  <= 1'b0;
            end
            case (state_q)
                WR_REQ: begin
                    if (m_awready)     m_awvalid <= 1'b0;
                    if (m_wready)      m_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) m_bready  <= 1'b1;
                end
                WR_RESP: if (m_bvalid) begin
                    m_bready   <= 1'b0;
                    status_out <= m_bresp;
                    done_out   <= 1'b1;
                end
                RD_REQ: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                end
                RD_RESP: if (m_rvalid) begin
                    m_rready   <= 1'b0;
                    rdata_out  <= m_rdata;
                    status_out <= m_rresp;
                    done_out   <= 1'b1;
                end
                default: ;
            endcase
`ifdef AXI_LITE_MST_CMD_BUF_EN
            if (store) begin
                buf_vld  <= 1'b1;
                buf_wr   <= wr_cmd;
                buf_addr <= addr_in;
                buf_data <= data_in;
            end else if (state_q == IDLE && buf_vld) begin
                buf_vld  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_mst_seq.sv
// Purpose : directed self-checking bench for axi_lite_mst_seq; slave handshakes are driven cycle by cycle.
// Timing  : inputs change and outputs are sampled 1 ns after each rising clock edge.
// Build   : the buffered-command scenario runs when AXI_LITE_MST_CMD_BUF_EN is defined, the drop scenario otherwise.
module tb_axi_lite_mst_seq;

    logic        clk, rstn;
    logic [31:0] addr_in, data_in;
    logic        wr_cmd, rd_cmd;
    logic        done_out;
    logic [1:0]  status_out;
    logic [31:0] rdata_out;
    logic        busy, cmd_drop;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid, m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;

    int n_chk  = 0;
    int n_pass = 0;

    axi_lite_mst_seq #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .clk(clk), .rstn(rstn),
        .addr_in(addr_in), .data_in(data_in), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
        .done_out(done_out), .status_out(status_out), .rdata_out(rdata_out),
        .busy(busy), .cmd_drop(cmd_drop),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        addr_in = '0; data_in = '0; wr_cmd = 0; rd_cmd = 0;
        m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = 0; m_rvalid = 0;
        #3;
        n_chk++;
        if ({done_out, status_out, busy, cmd_drop, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 11'b0)
            $display("FAIL reset_ctrl got %b exp 0", {done_out, status_out, busy, cmd_drop, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        else n_pass++;
        n_chk++;
        if ({rdata_out, m_awaddr, m_wdata, m_wstrb, m_araddr, m_awprot, m_arprot} !== 138'b0)
            $display("FAIL reset_data got nonzero rdata=%h awaddr=%h wdata=%h wstrb=%h araddr=%h", rdata_out, m_awaddr, m_wdata, m_wstrb, m_araddr);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        addr_in = 32'h0000_0100; data_in = 32'hDEAD_BEEF; wr_cmd = 1;
        tick();  // cycle 1
        wr_cmd = 0;
        n_chk++;
        if ({m_awvalid, m_wvalid, busy} !== 3'b111) $display("FAIL wr_valids got %b exp 111", {m_awvalid, m_wvalid, busy});
        else n_pass++;
        n_chk++;
        if ({m_awaddr, m_wdata, m_wstrb} !== {32'h100, 32'hDEADBEEF, 4'hF})
            $display("FAIL wr_payload got %h/%h/%h exp 100/deadbeef/f", m_awaddr, m_wdata, m_wstrb);
        else n_pass++;
        m_awready = 1; m_wready = 1;
        tick();  // cycle 2
        n_chk++;
        if ({m_awvalid, m_wvalid, m_bready, done_out} !== 4'b0010) $display("FAIL wr_bready got %b exp 0010", {m_awvalid, m_wvalid, m_bready, done_out});
        else n_pass++;
        m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b00;
        tick();  // cycle 3
        m_bvalid = 0;
        n_chk++;
        if ({done_out, status_out, m_bready, busy} !== 5'b10000) $display("FAIL wr_done got %b exp 10000", {done_out, status_out, m_bready, busy});
        else n_pass++;
    endtask

    task automatic test_read_wait();
        addr_in = 32'h0000_0200; rd_cmd = 1;
        tick();  // cycle 1
        rd_cmd = 0;
        n_chk++;
        if ({m_arvalid, done_out, m_araddr} !== {1'b1, 1'b0, 32'h200}) $display("FAIL rd_ar got v=%b done=%b a=%h exp 1/0/200", m_arvalid, done_out, m_araddr);
        else n_pass++;
        m_arready = 1;
        tick();  // cycle 2
        m_arready = 0;
        n_chk++;
        if ({m_arvalid, m_rready} !== 2'b01) $display("FAIL rd_rready got %b exp 01", {m_arvalid, m_rready});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if ({m_rready, done_out, busy} !== 3'b101) $display("FAIL rd_wait%0d got %b exp 101", i, {m_rready, done_out, busy});
            else n_pass++;
        end
        m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b10;
        tick();
        m_rvalid = 0; m_rdata = '0; m_rresp = 0;
        n_chk++;
        if ({done_out, status_out, m_rready, busy, rdata_out} !== {1'b1, 2'b10, 1'b0, 1'b0, 32'h12345678})
            $display("FAIL rd_done got done=%b st=%b rr=%b busy=%b rdata=%h exp 1/10/0/0/12345678", done_out, status_out, m_rready, busy, rdata_out);
        else n_pass++;
    endtask

    task automatic test_aw_late();
        addr_in = 32'h0000_0300; data_in = 32'hA5A5_0001; wr_cmd = 1;
        tick();  // cycle 1
        wr_cmd = 0;
        m_wready = 1;
        tick();  // cycle 2
        m_wready = 0;
        n_chk++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b100) $display("FAIL late_c2 got %b exp 100", {m_awvalid, m_wvalid, m_bready});
        else n_pass++;
        tick();  // cycle 3
        n_chk++;
        if ({m_awvalid, m_wvalid, m_bready, m_awaddr} !== {3'b100, 32'h300}) $display("FAIL late_c3 got %b a=%h exp 100/300", {m_awvalid, m_wvalid, m_bready}, m_awaddr);
        else n_pass++;
        tick();  // cycle 4
        n_chk++;
        if ({m_awvalid, m_bready} !== 2'b10) $display("FAIL late_c4 got %b exp 10", {m_awvalid, m_bready});
        else n_pass++;
        m_awready = 1;
        tick();  // cycle 5
        m_awready = 0;
        n_chk++;
        if ({m_awvalid, m_bready} !== 2'b01) $display("FAIL late_c5 got %b exp 01", {m_awvalid, m_bready});
        else n_pass++;
        m_bvalid = 1; m_bresp = 2'b01;
        tick();  // cycle 6
        m_bvalid = 0; m_bresp = 0;
        n_chk++;
        if ({done_out, status_out, m_bready, rdata_out} !== {1'b1, 2'b01, 1'b0, 32'h12345678})
            $display("FAIL late_done got done=%b st=%b br=%b rdata=%h exp 1/01/0/12345678", done_out, status_out, m_bready, rdata_out);
        else n_pass++;
        tick();
        n_chk++;
        if ({done_out, busy, m_awvalid, m_wvalid} !== 4'b1000) $display("FAIL late_idle got %b exp 1000", {done_out, busy, m_awvalid, m_wvalid});
        else n_pass++;
    endtask

    task automatic test_busy_cmd();
        addr_in = 32'h0000_0400; data_in = 32'h0000_0011; wr_cmd = 1;
        tick();  // cycle 1
        wr_cmd = 0;
        addr_in = 32'h0000_0500; rd_cmd = 1;
        tick();  // cycle 2
        rd_cmd = 0;
`ifdef AXI_LITE_MST_CMD_BUF_EN
        n_chk++;
        if ({cmd_drop, m_arvalid} !== 2'b00) $display("FAIL buf_store got %b exp 00", {cmd_drop, m_arvalid});
        else n_pass++;
        addr_in = 32'h0000_0600; data_in = 32'h66; wr_cmd = 1;
        tick();  // cycle 3
        wr_cmd = 0;
        n_chk++;
        if (cmd_drop !== 1'b1) $display("FAIL buf_full_drop got %b exp 1", cmd_drop);
        else n_pass++;
`else
        n_chk++;
        if ({cmd_drop, m_arvalid, m_awvalid} !== 3'b101) $display("FAIL busy_drop got %b exp 101", {cmd_drop, m_arvalid, m_awvalid});
        else n_pass++;
        tick();  // cycle 3
        n_chk++;
        if (cmd_drop !== 1'b0) $display("FAIL drop_pulse got %b exp 0", cmd_drop);
        else n_pass++;
`endif
        m_awready = 1; m_wready = 1;
        tick();
        m_awready = 0; m_wready = 0;
        n_chk++;
        if ({m_bready, m_awaddr, m_wdata} !== {1'b1, 32'h400, 32'h11}) $display("FAIL busy_wr got br=%b a=%h d=%h exp 1/400/11", m_bready, m_awaddr, m_wdata);
        else n_pass++;
        m_bvalid = 1;
        tick();
        m_bvalid = 0;
        n_chk++;
        if ({done_out, busy, m_arvalid} !== 3'b100) $display("FAIL busy_wr_done got %b exp 100", {done_out, busy, m_arvalid});
        else n_pass++;
        tick();
`ifdef AXI_LITE_MST_CMD_BUF_EN
        n_chk++;
        if ({m_arvalid, done_out, m_araddr} !== {1'b1, 1'b0, 32'h500}) $display("FAIL buf_launch got v=%b done=%b a=%h exp 1/0/500", m_arvalid, done_out, m_araddr);
        else n_pass++;
        m_arready = 1;
        tick();
        m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h55; m_rresp = 0;
        tick();
        m_rvalid = 0; m_rdata = '0;
        n_chk++;
        if ({done_out, rdata_out, busy} !== {1'b1, 32'h55, 1'b0}) $display("FAIL buf_rd_done got done=%b rdata=%h busy=%b", done_out, rdata_out, busy);
        else n_pass++;
        tick();
        n_chk++;
        if ({busy, m_awvalid, m_arvalid} !== 3'b000) $display("FAIL buf_empty got %b exp 000", {busy, m_awvalid, m_arvalid});
        else n_pass++;
`else
        n_chk++;
        if ({m_arvalid, busy, done_out} !== 3'b001) $display("FAIL no_ar got %b exp 001", {m_arvalid, busy, done_out});
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        addr_in = 32'h0000_0900; data_in = 32'h9; wr_cmd = 1; rd_cmd = 1;
        tick();  // cycle 1
        wr_cmd = 0; rd_cmd = 0;
        n_chk++;
        if ({m_awvalid, m_arvalid, cmd_drop, m_awaddr} !== {3'b101, 32'h900}) $display("FAIL both_cmd got %b a=%h exp 101/900", {m_awvalid, m_arvalid, cmd_drop}, m_awaddr);
        else n_pass++;
        m_awready = 1; m_wready = 1;
        tick();  // cycle 2
        m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 0;
        tick();  // cycle 3
        m_bvalid = 0;
        n_chk++;
        if ({done_out, busy, cmd_drop} !== 3'b100) $display("FAIL b2b_done got %b exp 100", {done_out, busy, cmd_drop});
        else n_pass++;
        addr_in = 32'h0000_0A00; rd_cmd = 1;
        tick();  // cycle 4
        rd_cmd = 0;
        n_chk++;
        if ({m_arvalid, done_out, cmd_drop, m_araddr} !== {3'b100, 32'hA00}) $display("FAIL b2b_ar got %b a=%h exp 100/a00", {m_arvalid, done_out, cmd_drop}, m_araddr);
        else n_pass++;
        m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'h0000_BEEF; m_rresp = 2'b11;
        tick();
        m_rvalid = 0; m_rdata = '0; m_rresp = 0;
        n_chk++;
        if ({done_out, status_out, rdata_out} !== {1'b1, 2'b11, 32'hBEEF}) $display("FAIL b2b_rd got done=%b st=%b rdata=%h exp 1/11/beef", done_out, status_out, rdata_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        addr_in = 32'h0000_0700; rd_cmd = 1;
        tick();
        rd_cmd = 0;
        tick();
        n_chk++;
        if ({m_arvalid, busy} !== 2'b11) $display("FAIL mid_wait got %b exp 11", {m_arvalid, busy});
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, done_out, busy, rdata_out} !== {7'b0, 32'h0})
            $display("FAIL mid_reset got %b rdata=%h exp all 0", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, done_out, busy}, rdata_out);
        else n_pass++;
        tick();
        rstn = 1'b1;
        tick();
        addr_in = 32'h0000_0800; rd_cmd = 1;
        tick();
        rd_cmd = 0;
        n_chk++;
        if ({m_arvalid, m_araddr} !== {1'b1, 32'h800}) $display("FAIL post_rst_ar got v=%b a=%h exp 1/800", m_arvalid, m_araddr);
        else n_pass++;
        m_arready = 1;
        tick();
        m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0008; m_rresp = 0;
        tick();
        m_rvalid = 0; m_rdata = '0;
        n_chk++;
        if ({done_out, status_out, busy, rdata_out} !== {4'b1000, 32'hCAFE0008}) $display("FAIL post_rst_rd got done=%b st=%b busy=%b rdata=%h", done_out, status_out, busy, rdata_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_aw_late();
        test_busy_cmd();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
